irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Bus-mapped interrupt controller upstream of the CPU: latches N_SRC peripheral requests, applies mask,
//  picks the lowest-numbered enabled pending source, and drives the CPU int_in/int_num pair until int_ack.
//  Register slave on the shared system bus, beside the RAM and UART slaves.
// PARAMETERS
//  N_SRC     8              number of request inputs (1..16)
//  BASE_ADDR 32'h0FFF_FFC0  word address of register 0 (compared against BUS_addr[31:3])
//  VEC_BASE  20'h00020      int_num = VEC_BASE + source id
// PORTS
//  clk        in    1      system clock (only clock)
//  clr_in     in    1      reset, synchronous, active-low
//  BUS_addr   in    32     word address ({2'b00,byte_addr[31:2]})
//  BUS_data   inout 32     bus data; driven only during a selected read, else 'z'
//  BUS_req    in    1      bus request from current master
//  BUS_RW     in    1      1 = write, 0 = read
//  BUS_ready  inout 1      driven 1 while responding, 'z' otherwise
//  irq_src    in    N_SRC  asynchronous peripheral requests, active-high
//  int_out    out   1      interrupt request to CPU int_in
//  int_num    out   20     vector of the request being presented
//  int_ack    in    1      CPU acknowledge, sampled high for >=1 cycle
// BEHAVIOUR
//  Reset (clr_in=0 at clk edge): int_out=0, int_num=0, PENDING=0, MASK=0, EDGE=all 1, FSM=IDLE,
//   BUS_ready/BUS_data='z'; applies mid-handshake and mid-bus-access, no completion.
//  irq_src passes 2-flop sync; EDGE[i]=1: rising edge sets PENDING[i]; EDGE[i]=0: PENDING[i]=synced level.
//  Registers (offset = BUS_addr[2:0]): 0 PENDING R/W1C (W1C ignored on level bits); 1 MASK RW (1=enable);
//   2 EDGE RW; 3 STATUS R {state[1:0] at [31:30], cur_id[3:0] at [3:0]}; 4-7 read 0, writes ignored.
//  Bus: select = BUS_req & BUS_addr[31:3]==BASE_ADDR[31:3]. Cycle after select first seen: BUS_ready=1,
//   read data on BUS_data; write committed exactly once in that cycle; ready held while BUS_req stays high,
//   released to 'z' the cycle after BUS_req falls.
//  FSM: IDLE -> REQ when |(PENDING&MASK): latch cur_id = lowest set index, int_num=VEC_BASE+cur_id, int_out=1.
//   REQ -> ACKD on int_ack=1: int_out=0, clear PENDING[cur_id] if edge type.
//   ACKD -> IDLE when int_ack=0 (no re-request until ack drops). Request-to-int_out latency 1 cycle from
//   pending set; source-to-pending 3 cycles (sync+edge).
//  int_num stable for whole of REQ; MASK/EDGE/W1C changes during REQ never retract or renumber it.
//  Simultaneous set (new edge) and clear (ack or W1C) of same bit: set wins, bit stays 1.
//  Level source dropping during REQ: request still held until ack; clear-on-ack has no effect.
//  N_SRC<16: unused PENDING/MASK/EDGE bits read 0.
// CONFIGURATION
//  IRQ_CTRL_SWI_EN defined: offset 4 = SWI, write-only; writing 1s sets PENDING bits (set regardless of EDGE;
//   on level bits held until next sync update overwrites). Reads return 0.
//  Not defined: offset 4 behaves as reserved (read 0, write ignored); no extra logic.
// STRUCTURE
//  irq_ctrl_defs.vh: register offsets, FSM state encodings (IDLE=0,REQ=1,ACKD=2), reset values.
//  Sub-module irq_prio_enc: combinational N_SRC-bit lowest-index encoder -> {valid, id[3:0]}.
//  Top holds sync, pending/mask/edge regs, bus slave, FSM.
// TESTING
//  Reset: clr_in=0 2 cycles -> int_out=0, read MASK=0, EDGE=8'hFF, BUS_ready='z'.
//  MASK=8'h28, pulse irq_src[3] and [5] same cycle -> int_num=0x23 first; ack -> then 0x25; PENDING=0 after.
//  Masked source: MASK=0, pulse irq_src[1] -> int_out stays 0, PENDING reads 8'h02; write MASK=2 ->
//   int_out=1 next cycle, int_num=0x21.
//  Level source: EDGE[0]=0, MASK=1, hold irq_src[0]=1 -> ack, drop ack -> re-requests 0x20; release -> idle.
//  Edge arrives on [2] in ack cycle of id 2 -> PENDING[2] stays 1, second request 0x22 issued.
//  SWI (macro on): write offset4=8'h80, MASK=8'h80 -> int_num=0x27; macro off: no request, read 0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the bus-mapped interrupt controller:
//   - register offsets within the 8-word window
//   - FSM state encoding (IDLE=0, REQ=1, ACKD=2)
//   - reset values of the CPU-facing outputs
//   - helpers for vector computation and STATUS word packing
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

    // Register offsets (BUS_addr[2:0])
    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_MASK    = 3'd1;
    localparam logic [2:0] OFF_EDGE    = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_SWI     = 3'd4;

    // Handshake FSM towards the CPU
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKD = 2'd2
    } irq_state_t;

    // Reset values of the CPU-facing outputs
    localparam logic        RST_INT_OUT = 1'b0;
    localparam logic [19:0] RST_INT_NUM = 20'd0;
    localparam logic [3:0]  RST_CUR_ID  = 4'd0;

    // Vector presented to the CPU for a given source id
    function automatic logic [19:0] vec_of(input logic [19:0] base, input logic [3:0] id);
        return base + {16'd0, id};
    endfunction

    // STATUS register layout: state in [31:30], current id in [3:0]
    function automatic logic [31:0] status_word(input irq_state_t st, input logic [3:0] id);
        return {st, 26'd0, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational lowest-index priority encoder.
// Ports:
//   req   [N-1:0]  request vector (already masked)
//   valid          at least one request bit is set
//   id    [3:0]    index of the lowest set request bit (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   id
);

    // first[i] is set only for the lowest set request bit, so at most one
    // id_term is non-zero and the OR-reduction below yields its index.
    logic [N-1:0]      first;
    logic [N-1:0][3:0] id_term;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            localparam logic [N-1:0] BELOW_MASK = N'((32'd1 << gi) - 32'd1);
            assign first[gi]   = req[gi] & ~(|(req & BELOW_MASK));
            assign id_term[gi] = first[gi] ? 4'(gi) : 4'd0;
        end
    endgenerate

    always_comb begin
        id = 4'd0;
        for (int i = 0; i < N; i++) begin
            id = id | id_term[i];
        end
    end

    assign valid = |req;

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Bus-mapped interrupt controller sitting in front of the CPU interrupt input.
// Latches N_SRC peripheral requests (edge or level), applies a mask, picks the
// lowest-numbered enabled pending source and holds int_out/int_num until the
// CPU acknowledges with int_ack.
//
// Ports:
//   clk        system clock
//   clr_in     synchronous active-low reset
//   BUS_addr   word address; [31:3] selects the block, [2:0] the register
//   BUS_data   bidirectional data, driven only during a selected read
//   BUS_req    bus request from the current master
//   BUS_RW     1 = write, 0 = read
//   BUS_ready  driven 1 while responding, high-impedance otherwise
//   irq_src    asynchronous active-high peripheral requests
//   int_out    interrupt request to the CPU
//   int_num    vector of the request being presented (VEC_BASE + id)
//   int_ack    CPU acknowledge
//
// Registers: 0 PENDING (R/W1C, edge bits only), 1 MASK, 2 EDGE,
//            3 STATUS (read-only), 4-7 read as zero.
// Build option IRQ_CTRL_SWI_EN: offset 4 becomes a write-only software
// interrupt register whose written ones set PENDING bits.
// -----------------------------------------------------------------------------
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0FFF_FFC0,
    parameter logic [19:0] VEC_BASE  = 20'h00020
) (
    input  logic             clk,
    input  logic             clr_in,
    input  logic [31:0]      BUS_addr,
    inout  wire  [31:0]      BUS_data,
    input  logic             BUS_req,
    input  logic             BUS_RW,
    inout  wire              BUS_ready,
    input  logic [N_SRC-1:0] irq_src,
    output logic             int_out,
    output logic [19:0]      int_num,
    input  logic             int_ack
);

    // ---------------------------------------------------------------------
    // Request synchroniser and edge detector
    // ---------------------------------------------------------------------
    logic [N_SRC-1:0] sync1_reg;
    logic [N_SRC-1:0] sync2_reg;
    logic [N_SRC-1:0] prev_reg;
    logic [N_SRC-1:0] rise;

    always_ff @(posedge clk) begin
        if (!clr_in) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= irq_src;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~prev_reg;

    // ---------------------------------------------------------------------
    // Register state
    // ---------------------------------------------------------------------
    logic [N_SRC-1:0] pending_reg, pending_next;
    logic [N_SRC-1:0] mask_reg,    mask_next;
    logic [N_SRC-1:0] edge_reg,    edge_next;

    irq_state_t       state_reg,   state_next;
    logic [3:0]       cur_id_reg,  cur_id_next;
    logic             int_out_reg, int_out_next;
    logic [19:0]      int_num_reg, int_num_next;

    // ---------------------------------------------------------------------
    // Bus slave
    // ---------------------------------------------------------------------
    logic             busy_reg, busy_next;
    logic             rw_reg;
    logic [31:0]      rd_data_reg;
    logic [31:0]      rd_word;
    logic             sel;
    logic             start;
    logic             wr_en;
    logic [2:0]       off;
    logic [N_SRC-1:0] wdata;
    logic             wr_pend;
    logic             wr_mask;
    logic             wr_edge;
    logic [N_SRC-1:0] swi_set;
    logic             unused_bus_bits;

    assign sel     = BUS_req && (BUS_addr[31:3] == BASE_ADDR[31:3]);
    // An access is accepted only once; the slave then stays busy until the
    // master drops BUS_req, so a held request never commits a second write.
    assign start   = sel && !busy_reg;
    assign wr_en   = start && BUS_RW;
    assign off     = BUS_addr[2:0];
    assign wdata   = BUS_data[N_SRC-1:0];
    assign wr_pend = wr_en && (off == OFF_PENDING);
    assign wr_mask = wr_en && (off == OFF_MASK);
    assign wr_edge = wr_en && (off == OFF_EDGE);

    generate
        if (N_SRC < 32) begin : g_unused
            assign unused_bus_bits = ^BUS_data[31:N_SRC];
        end else begin : g_nounused
            assign unused_bus_bits = 1'b0;
        end
    endgenerate

`ifdef IRQ_CTRL_SWI_EN
    assign swi_set = (wr_en && (off == OFF_SWI)) ? wdata : '0;
`else
    assign swi_set = '0;
`endif

    always_comb begin
        rd_word = 32'd0;
        case (off)
            OFF_PENDING: rd_word = 32'(pending_reg);
            OFF_MASK:    rd_word = 32'(mask_reg);
            OFF_EDGE:    rd_word = 32'(edge_reg);
            OFF_STATUS:  rd_word = status_word(state_reg, cur_id_reg);
            OFF_SWI:     rd_word = 32'd0;
            default:     rd_word = 32'd0;
        endcase
    end

    always_comb begin
        busy_next = busy_reg;
        if (busy_reg) begin
            busy_next = BUS_req;
        end else if (sel) begin
            busy_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_in) begin
            busy_reg    <= 1'b0;
            rw_reg      <= 1'b0;
            rd_data_reg <= 32'd0;
        end else begin
            busy_reg <= busy_next;
            if (start) begin
                rw_reg      <= BUS_RW;
                rd_data_reg <= rd_word;
            end
        end
    end

    assign BUS_ready = busy_reg ? 1'b1 : 1'bz;
    assign BUS_data  = (busy_reg && !rw_reg) ? rd_data_reg : 32'bz;

    // ---------------------------------------------------------------------
    // PENDING / MASK / EDGE next-state
    // ---------------------------------------------------------------------
    logic ack_clr_en;

    assign ack_clr_en = (state_reg == ST_REQ) && int_ack;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
            logic set_bit;
            logic clr_bit;
            assign set_bit = rise[gi] | swi_set[gi];
            assign clr_bit = (wr_pend && wdata[gi]) ||
                             (ack_clr_en && (cur_id_reg == 4'(gi)));
            // Edge bits: a set in the same cycle as a clear wins.
            // Level bits: follow the synchronised input; W1C and ack have no
            // effect, and a software set only lasts until the next sample.
            assign pending_next[gi] = edge_reg[gi]
                                    ? (set_bit | (pending_reg[gi] & ~clr_bit))
                                    : (sync2_reg[gi] | swi_set[gi]);
        end
    endgenerate

    assign mask_next = wr_mask ? wdata : mask_reg;
    assign edge_next = wr_edge ? wdata : edge_reg;

    always_ff @(posedge clk) begin
        if (!clr_in) begin
            pending_reg <= '0;
            mask_reg    <= '0;
            edge_reg    <= '1;
        end else begin
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            edge_reg    <= edge_next;
        end
    end

    // ---------------------------------------------------------------------
    // Priority selection and CPU handshake FSM
    // ---------------------------------------------------------------------
    logic       enc_valid;
    logic [3:0] enc_id;

    irq_prio_enc #(
        .N (N_SRC)
    ) u_prio_enc (
        .req   (pending_reg & mask_reg),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // cur_id and int_num are only loaded on the IDLE->REQ transition, so
    // register writes during REQ cannot renumber or retract the request.
    always_comb begin
        state_next   = state_reg;
        cur_id_next  = cur_id_reg;
        int_out_next = int_out_reg;
        int_num_next = int_num_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_next   = ST_REQ;
                    cur_id_next  = enc_id;
                    int_num_next = vec_of(VEC_BASE, enc_id);
                    int_out_next = 1'b1;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_next   = ST_ACKD;
                    int_out_next = 1'b0;
                end
            end
            ST_ACKD: begin
                // Wait for the CPU to release ack before re-arbitrating.
                if (!int_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                int_out_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_in) begin
            state_reg   <= ST_IDLE;
            cur_id_reg  <= RST_CUR_ID;
            int_out_reg <= RST_INT_OUT;
            int_num_reg <= RST_INT_NUM;
        end else begin
            state_reg   <= state_next;
            cur_id_reg  <= cur_id_next;
            int_out_reg <= int_out_next;
            int_num_reg <= int_num_next;
        end
    end

    assign int_out = int_out_reg;
    assign int_num = int_num_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Scoreboard bench for irq_ctrl. Stimulus pushes expected interrupt vectors
// and expected read data into queues; a monitor pops and compares whenever
// the DUT raises int_out or answers a read with BUS_ready.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h0FFF_FFC0;
    localparam logic [19:0] VEC  = 20'h00020;

    logic        clk = 1'b0;
    logic        clr_in;
    logic [31:0] bus_addr;
    logic        bus_req;
    logic        bus_rw;
    logic        tb_drv;
    logic [31:0] tb_wdata;
    wire  [31:0] bus_data;
    wire         bus_ready;
    logic [7:0]  irq_src;
    logic        int_out;
    logic [19:0] int_num;
    logic        ack_auto;
    logic        ack_force;
    logic        ack_en;
    wire         int_ack_w;

    assign bus_data  = tb_drv ? tb_wdata : 32'bz;
    assign int_ack_w = ack_auto | ack_force;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_SRC     (8),
        .BASE_ADDR (BASE),
        .VEC_BASE  (VEC)
    ) dut (
        .clk       (clk),
        .clr_in    (clr_in),
        .BUS_addr  (bus_addr),
        .BUS_data  (bus_data),
        .BUS_req   (bus_req),
        .BUS_RW    (bus_rw),
        .BUS_ready (bus_ready),
        .irq_src   (irq_src),
        .int_out   (int_out),
        .int_num   (int_num),
        .int_ack   (int_ack_w)
    );

    int checks   = 0;
    int failures = 0;

    logic [19:0] int_q[$];
    logic [31:0] rd_q[$];
    string       rd_name_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end else begin
            $display("check %s value=0x%08h ok", name, act);
        end
    endtask

    // ---------------- monitor: interrupts and read responses ----------------
    logic        int_prev = 1'b0;
    logic [19:0] held_num = 20'd0;
    logic        rdy_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (int_out === 1'b1 && !int_prev) begin
                if (int_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_int actual=0x%05h required=none", int_num);
                end else begin
                    chk("int_num", 32'(int_num), 32'(int_q.pop_front()));
                end
                held_num = int_num;
            end else if (int_out === 1'b1 && int_prev && int_num !== held_num) begin
                checks++; failures++;
                $display("FAIL int_num_stable actual=0x%05h required=0x%05h", int_num, held_num);
            end
            int_prev = (int_out === 1'b1);

            if (bus_ready === 1'b1 && !rdy_prev && !bus_rw) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read actual=0x%08h required=none", bus_data);
                end else begin
                    chk(rd_name_q.pop_front(), bus_data, rd_q.pop_front());
                end
            end
            rdy_prev = (bus_ready === 1'b1);
        end
    end

    // ---------------- CPU acknowledge responder ----------------
    initial begin
        ack_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && int_out === 1'b1 && int_ack_w === 1'b0) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk); #1 ack_auto = 1'b1;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1 ack_auto = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_xfer(input logic rw, input logic [2:0] off, input logic [31:0] wd);
        logic got;
        @(posedge clk); #1;
        bus_addr = {BASE[31:3], off};
        bus_rw   = rw;
        bus_req  = 1'b1;
        tb_drv   = rw;
        tb_wdata = wd;
        got      = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL bus_ready_timeout actual=none required=ready off=%0d", off);
        end
        @(posedge clk); #1;
        bus_req = 1'b0;
        tb_drv  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        bus_xfer(1'b1, off, d);
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        bus_xfer(1'b0, off, 32'd0);
    endtask

    task automatic pulse(input logic [7:0] p);
        @(posedge clk); #1 irq_src = p;
        @(posedge clk); #1 irq_src = 8'd0;
    endtask

    task automatic wait_int(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (int_out === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s actual=int_out_low required=int_out_high", name);
        end
    endtask

    task automatic manual_ack();
        @(posedge clk); #1 ack_force = 1'b1;
        repeat (2) @(posedge clk);
        #1 ack_force = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((int_q.size() != 0 || int_out === 1'b1 || int_ack_w === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d_left required=0", int_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    int lat;
    logic seen_int;

    initial begin
        clr_in    = 1'b0;
        bus_addr  = 32'd0;
        bus_req   = 1'b0;
        bus_rw    = 1'b0;
        tb_drv    = 1'b0;
        tb_wdata  = 32'd0;
        irq_src   = 8'd0;
        ack_force = 1'b0;
        ack_en    = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_int_out", 32'(int_out), 32'd0);
        chk("rst_int_num", 32'(int_num), 32'd0);
        chk("rst_ready_released", 32'(bus_ready === 1'b1), 32'd0);
        @(posedge clk); #1 clr_in = 1'b1;
        rd(OFF_MASK,    32'h0000_0000, "rst_mask");
        rd(OFF_EDGE,    32'h0000_00FF, "rst_edge");
        rd(OFF_PENDING, 32'h0000_0000, "rst_pending");
        rd(OFF_STATUS,  32'h0000_0000, "rst_status");
        rd(3'd6,        32'h0000_0000, "rsvd6_read");
        @(negedge clk);
        chk("ready_released_after_read", 32'(bus_ready === 1'b1), 32'd0);

        // Two simultaneous edges, lowest first; source-to-int_out latency
        wr(OFF_MASK, 32'h28);
        int_q.push_back(VEC + 20'd3);
        int_q.push_back(VEC + 20'd5);
        @(posedge clk); #1 irq_src = 8'h28;
        lat = 0;
        seen_int = 1'b0;
        for (int n = 1; n <= 20 && !seen_int; n++) begin
            @(negedge clk);
            if (n == 2) irq_src = 8'd0;
            if (int_out === 1'b1) begin
                seen_int = 1'b1;
                lat = n;
            end
        end
        chk("src_to_int_latency", 32'(lat), 32'd5);
        rd(OFF_STATUS, 32'h4000_0003, "status_req3");
        ack_en = 1'b1;
        drain();
        rd(OFF_PENDING, 32'h0, "pend_after_28");

        // Masked source, later enabled
        ack_en = 1'b0;
        wr(OFF_MASK, 32'h0);
        pulse(8'h02);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("masked_no_int", 32'(int_out), 32'd0);
        rd(OFF_PENDING, 32'h02, "pend_masked");
        int_q.push_back(VEC + 20'd1);
        wr(OFF_MASK, 32'h02);
        chk("unmask_int_out", 32'(int_out), 32'd1);
        ack_en = 1'b1;
        drain();
        rd(OFF_PENDING, 32'h0, "pend_after_unmask");

        // Level source: re-request after ack drops, hold while source drops
        ack_en = 1'b0;
        wr(OFF_EDGE, 32'hFE);
        wr(OFF_MASK, 32'h01);
        int_q.push_back(VEC);
        @(posedge clk); #1 irq_src = 8'h01;
        wait_int("level_first");
        rd(OFF_STATUS, 32'h4000_0000, "status_req0");
        int_q.push_back(VEC);
        manual_ack();
        wait_int("level_rerequest");
        irq_src = 8'h00;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("level_held_until_ack", 32'(int_out), 32'd1);
        manual_ack();
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("level_idle", 32'(int_out), 32'd0);
        rd(OFF_PENDING, 32'h0, "pend_level_released");
        rd(OFF_STATUS,  32'h0, "status_idle");
        wr(OFF_EDGE, 32'hFF);

        // New edge on id 2 exactly in the ack cycle of id 2: set wins
        wr(OFF_MASK, 32'h04);
        int_q.push_back(VEC + 20'd2);
        int_q.push_back(VEC + 20'd2);
        pulse(8'h04);
        wait_int("edge_first");
        @(posedge clk); #1 irq_src = 8'h04;
        @(posedge clk); #1;
        @(posedge clk); #1 ack_force = 1'b1;
        @(posedge clk); #1 ack_force = 1'b0; irq_src = 8'h00;
        wait_int("edge_second");
        rd(OFF_PENDING, 32'h04, "pend_set_wins");
        ack_en = 1'b1;
        drain();
        rd(OFF_PENDING, 32'h0, "pend_after_set_wins");

        // Randomized: mask, simultaneous pulses, W1C of masked residue
        for (int it = 0; it < 12; it++) begin
            logic [7:0] m;
            logic [7:0] p;
            logic [7:0] resid;
            logic [7:0] c;
            m = 8'($urandom);
            p = 8'($urandom_range(1, 255));
            c = 8'($urandom);
            wr(OFF_MASK, {24'd0, m});
            for (int i = 0; i < 8; i++) begin
                if (p[i] && m[i]) int_q.push_back(VEC + 20'(i));
            end
            pulse(p);
            repeat (4) @(posedge clk);
            drain();
            resid = p & ~m;
            rd(OFF_PENDING, {24'd0, resid}, "rand_pend_resid");
            wr(OFF_PENDING, {24'd0, c});
            rd(OFF_PENDING, {24'd0, resid & ~c}, "rand_pend_w1c");
            wr(OFF_PENDING, 32'hFF);
        end

        // Software interrupt register (build option)
        wr(OFF_MASK, 32'h0);
`ifdef IRQ_CTRL_SWI_EN
        int_q.push_back(VEC + 20'd7);
        wr(OFF_SWI, 32'h80);
        wr(OFF_MASK, 32'h80);
        drain();
        rd(OFF_PENDING, 32'h0, "pend_after_swi");
`else
        wr(OFF_SWI, 32'h80);
        wr(OFF_MASK, 32'h80);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("swi_off_no_int", 32'(int_out), 32'd0);
        rd(OFF_PENDING, 32'h0, "pend_swi_off");
`endif
        rd(OFF_SWI, 32'h0, "swi_reads_zero");

        repeat (10) @(posedge clk);
        chk("int_queue_empty", 32'(int_q.size()), 32'd0);
        chk("read_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
